// File: rtl/fft_pingpong_cplx_ram.sv
// Double-buffered complex sample RAM for the FFT datapath: the butterfly ports work on the
// active bank while the I/O port streams the shadow bank; a swap handshake exchanges them.
module fft_pingpong_cplx_ram #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 8,
  parameter int OUT_REG = 0
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              WE_top,
  input  logic              WE_bot,
  input  logic [ADDR_W-1:0] addr_top,
  input  logic [ADDR_W-1:0] addr_bot,
  input  logic [DATA_W-1:0] din_top_re,
  input  logic [DATA_W-1:0] din_top_im,
  input  logic [DATA_W-1:0] din_bot_re,
  input  logic [DATA_W-1:0] din_bot_im,
  output logic [DATA_W-1:0] dout_top_re,
  output logic [DATA_W-1:0] dout_top_im,
  output logic [DATA_W-1:0] dout_bot_re,
  output logic [DATA_W-1:0] dout_bot_im,
  input  logic              io_we,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] io_din_re,
  input  logic [DATA_W-1:0] io_din_im,
  output logic [DATA_W-1:0] io_dout_re,
  output logic [DATA_W-1:0] io_dout_im,
  input  logic              swap_req,
  output logic              swap_ack,
  output logic              bank_sel,
  output logic              collision,
  input  logic              clr_coll
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SWAP = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [DATA_W-1:0] mem_re [0:2*DEPTH-1];
  logic [DATA_W-1:0] mem_im [0:2*DEPTH-1];

  logic [ADDR_W:0] top_idx;
  logic [ADDR_W:0] bot_idx;
  logic [ADDR_W:0] io_idx;
  logic            bot_drop;
  logic [1:0]      state;

  logic [DATA_W-1:0] rd_top_re, rd_top_im;
  logic [DATA_W-1:0] rd_bot_re, rd_bot_im;
  logic [DATA_W-1:0] rd_io_re, rd_io_im;

  // Both banks live in one array; the bank bit is the MSB of the physical index.
  assign top_idx  = {bank_sel, addr_top};
  assign bot_idx  = {bank_sel, addr_bot};
  assign io_idx   = {~bank_sel, io_addr};
  assign bot_drop = WE_top & WE_bot & (addr_top == addr_bot);

  always_ff @(posedge Clk) begin
    if (io_we) begin
      mem_re[io_idx] <= io_din_re;
      mem_im[io_idx] <= io_din_im;
    end
    if (WE_bot && !bot_drop) begin
      mem_re[bot_idx] <= din_bot_re;
      mem_im[bot_idx] <= din_bot_im;
    end
    if (WE_top) begin
      mem_re[top_idx] <= din_top_re;
      mem_im[top_idx] <= din_top_im;
    end
  end

  // Own-port writes bypass to the read register; other ports see the pre-edge array contents.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rd_top_re <= '0;
      rd_top_im <= '0;
      rd_bot_re <= '0;
      rd_bot_im <= '0;
      rd_io_re  <= '0;
      rd_io_im  <= '0;
    end else begin
      rd_top_re <= WE_top ? din_top_re : mem_re[top_idx];
      rd_top_im <= WE_top ? din_top_im : mem_im[top_idx];
      rd_bot_re <= WE_bot ? din_bot_re : mem_re[bot_idx];
      rd_bot_im <= WE_bot ? din_bot_im : mem_im[bot_idx];
      rd_io_re  <= io_we  ? io_din_re  : mem_re[io_idx];
      rd_io_im  <= io_we  ? io_din_im  : mem_im[io_idx];
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
          dout_top_re <= '0;
          dout_top_im <= '0;
          dout_bot_re <= '0;
          dout_bot_im <= '0;
          io_dout_re  <= '0;
          io_dout_im  <= '0;
        end else begin
          dout_top_re <= rd_top_re;
          dout_top_im <= rd_top_im;
          dout_bot_re <= rd_bot_re;
          dout_bot_im <= rd_bot_im;
          io_dout_re  <= rd_io_re;
          io_dout_im  <= rd_io_im;
        end
      end
    end else begin : g_no_out_reg
      assign dout_top_re = rd_top_re;
      assign dout_top_im = rd_top_im;
      assign dout_bot_re = rd_bot_re;
      assign dout_bot_im = rd_bot_im;
      assign io_dout_re  = rd_io_re;
      assign io_dout_im  = rd_io_im;
    end
  endgenerate

  // A new collision outranks a clear arriving in the same cycle.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      collision <= 1'b0;
    end else if (bot_drop) begin
      collision <= 1'b1;
    end else if (clr_coll) begin
      collision <= 1'b0;
    end
  end

  // HOLD waits for swap_req to drop so a level held high swaps exactly once.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= ST_IDLE;
      bank_sel <= 1'b0;
      swap_ack <= 1'b0;
    end else begin
      swap_ack <= 1'b0;
      case (state)
        ST_IDLE: if (swap_req) state <= ST_SWAP;
        ST_SWAP: begin
          bank_sel <= ~bank_sel;
          swap_ack <= 1'b1;
          state    <= ST_HOLD;
        end
        ST_HOLD: if (!swap_req) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_pingpong_cplx_ram.sv
// Self-checking bench for fft_pingpong_cplx_ram: directed vectors and scenarios on an
// OUT_REG=0 and an OUT_REG=1 instance driven in parallel, then random traffic against a model.
module tb_fft_pingpong_cplx_ram;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        WE_top, WE_bot, io_we, swap_req, clr_coll;
  logic [7:0]  addr_top, addr_bot, io_addr;
  logic [31:0] din_top_re, din_top_im, din_bot_re, din_bot_im, io_din_re, io_din_im;

  logic [31:0] d0_top_re, d0_top_im, d0_bot_re, d0_bot_im, d0_io_re, d0_io_im;
  logic [31:0] d1_top_re, d1_top_im, d1_bot_re, d1_bot_im, d1_io_re, d1_io_im;
  logic        d0_ack, d0_bank, d0_coll, d1_ack, d1_bank, d1_coll;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  fft_pingpong_cplx_ram #(.DATA_W(32), .ADDR_W(8), .OUT_REG(0)) u_dut0 (
    .Clk(Clk), .Reset_n(Reset_n),
    .WE_top(WE_top), .WE_bot(WE_bot), .addr_top(addr_top), .addr_bot(addr_bot),
    .din_top_re(din_top_re), .din_top_im(din_top_im),
    .din_bot_re(din_bot_re), .din_bot_im(din_bot_im),
    .dout_top_re(d0_top_re), .dout_top_im(d0_top_im),
    .dout_bot_re(d0_bot_re), .dout_bot_im(d0_bot_im),
    .io_we(io_we), .io_addr(io_addr), .io_din_re(io_din_re), .io_din_im(io_din_im),
    .io_dout_re(d0_io_re), .io_dout_im(d0_io_im),
    .swap_req(swap_req), .swap_ack(d0_ack), .bank_sel(d0_bank),
    .collision(d0_coll), .clr_coll(clr_coll)
  );

  fft_pingpong_cplx_ram #(.DATA_W(32), .ADDR_W(8), .OUT_REG(1)) u_dut1 (
    .Clk(Clk), .Reset_n(Reset_n),
    .WE_top(WE_top), .WE_bot(WE_bot), .addr_top(addr_top), .addr_bot(addr_bot),
    .din_top_re(din_top_re), .din_top_im(din_top_im),
    .din_bot_re(din_bot_re), .din_bot_im(din_bot_im),
    .dout_top_re(d1_top_re), .dout_top_im(d1_top_im),
    .dout_bot_re(d1_bot_re), .dout_bot_im(d1_bot_im),
    .io_we(io_we), .io_addr(io_addr), .io_din_re(io_din_re), .io_din_im(io_din_im),
    .io_dout_re(d1_io_re), .io_dout_im(d1_io_im),
    .swap_req(swap_req), .swap_ack(d1_ack), .bank_sel(d1_bank),
    .collision(d1_coll), .clr_coll(clr_coll)
  );

  // Behavioural reference: per-edge reads see the old array, own-port writes bypass.
  logic [63:0] mm [0:1][0:255];
  logic        m_bank, m_ack, m_coll;
  logic [1:0]  m_state;
  logic [63:0] m1_top, m1_bot, m1_io, m2_top, m2_bot, m2_io;

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      m_bank <= 1'b0; m_ack <= 1'b0; m_coll <= 1'b0; m_state <= 2'd0;
      m1_top <= '0; m1_bot <= '0; m1_io <= '0;
      m2_top <= '0; m2_bot <= '0; m2_io <= '0;
    end else begin
      m1_top <= WE_top ? {din_top_re, din_top_im} : mm[m_bank][addr_top];
      m1_bot <= WE_bot ? {din_bot_re, din_bot_im} : mm[m_bank][addr_bot];
      m1_io  <= io_we  ? {io_din_re, io_din_im}   : mm[!m_bank][io_addr];
      m2_top <= m1_top; m2_bot <= m1_bot; m2_io <= m1_io;
      if (io_we) mm[!m_bank][io_addr] <= {io_din_re, io_din_im};
      if (WE_bot && !(WE_top && addr_top == addr_bot)) mm[m_bank][addr_bot] <= {din_bot_re, din_bot_im};
      if (WE_top) mm[m_bank][addr_top] <= {din_top_re, din_top_im};
      if (WE_top && WE_bot && addr_top == addr_bot) m_coll <= 1'b1;
      else if (clr_coll) m_coll <= 1'b0;
      m_ack <= (m_state == 2'd1);
      if (m_state == 2'd1) m_bank <= !m_bank;
      case (m_state)
        2'd0: m_state <= swap_req ? 2'd1 : 2'd0;
        2'd1: m_state <= 2'd2;
        default: m_state <= swap_req ? 2'd2 : 2'd0;
      endcase
    end
  end

  typedef struct {
    logic [1:0]  port;
    logic [7:0]  addr;
    logic [31:0] re, im;
    logic [31:0] exp_re, exp_im;
  } vec_t;

  vec_t vecs [8];

  task automatic cycle();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic idleInputs();
    WE_top = 0; WE_bot = 0; io_we = 0; swap_req = 0; clr_coll = 0;
    addr_top = 0; addr_bot = 0; io_addr = 0;
    din_top_re = 0; din_top_im = 0; din_bot_re = 0; din_bot_im = 0;
    io_din_re = 0; io_din_im = 0;
  endtask

  // port: 0 = top, 1 = bot, 2 = io
  task automatic applyStimulus(input logic [1:0] port, input logic [7:0] addr,
                               input logic [31:0] re, input logic [31:0] im, input logic we);
    case (port)
      2'd0: begin WE_top = we; addr_top = addr; din_top_re = re; din_top_im = im; end
      2'd1: begin WE_bot = we; addr_bot = addr; din_bot_re = re; din_bot_im = im; end
      default: begin io_we = we; io_addr = addr; io_din_re = re; io_din_im = im; end
    endcase
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] portOut(input logic inst, input logic [1:0] port);
    case ({inst, port})
      3'b000: return {d0_top_re, d0_top_im};
      3'b001: return {d0_bot_re, d0_bot_im};
      3'b010: return {d0_io_re, d0_io_im};
      3'b100: return {d1_top_re, d1_top_im};
      3'b101: return {d1_bot_re, d1_bot_im};
      default: return {d1_io_re, d1_io_im};
    endcase
  endfunction

  task automatic doSwap();
    swap_req = 1; cycle();
    swap_req = 0; cycle();
    cycle();
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acks, toggles;
    logic prev_bank;

    vecs[0] = '{2'd0, 8'h00, 32'h7fffffff, 32'h80000000, 32'h7fffffff, 32'h80000000};
    vecs[1] = '{2'd0, 8'hff, 32'hffffffff, 32'h00000001, 32'hffffffff, 32'h00000001};
    vecs[2] = '{2'd1, 8'h01, 32'hfffffff9, 32'h00000003, 32'hfffffff9, 32'h00000003};
    vecs[3] = '{2'd1, 8'hfe, 32'h12345678, 32'h9abcdef0, 32'h12345678, 32'h9abcdef0};
    vecs[4] = '{2'd2, 8'h00, 32'hdeadbeef, 32'h0badf00d, 32'hdeadbeef, 32'h0badf00d};
    vecs[5] = '{2'd2, 8'hff, 32'h80000000, 32'h7fffffff, 32'h80000000, 32'h7fffffff};
    vecs[6] = '{2'd0, 8'h40, 32'h00000000, 32'hffffffff, 32'h00000000, 32'hffffffff};
    vecs[7] = '{2'd1, 8'h41, 32'h55555555, 32'haaaaaaaa, 32'h55555555, 32'haaaaaaaa};

    idleInputs();
    Reset_n = 0;
    repeat (3) cycle();
    checkOutput("reset_flags0", {61'd0, d0_bank, d0_ack, d0_coll}, 64'd0);
    checkOutput("reset_flags1", {61'd0, d1_bank, d1_ack, d1_coll}, 64'd0);
    for (int p = 0; p < 3; p++) begin
      checkOutput("reset_dout0", portOut(1'b0, p[1:0]), 64'd0);
      checkOutput("reset_dout1", portOut(1'b1, p[1:0]), 64'd0);
    end
    Reset_n = 1;
    cycle();

    // Write through each port, then read back at latency 1 (write-first) and latency 2
    for (int i = 0; i < 8; i++) begin
      idleInputs();
      applyStimulus(vecs[i].port, vecs[i].addr, vecs[i].re, vecs[i].im, 1'b1);
      cycle();
      checkOutput("vec_wfirst", portOut(1'b0, vecs[i].port), {vecs[i].exp_re, vecs[i].exp_im});
      applyStimulus(vecs[i].port, vecs[i].addr, 32'h0, 32'h0, 1'b0);
      cycle();
      checkOutput("vec_stored", portOut(1'b0, vecs[i].port), {vecs[i].exp_re, vecs[i].exp_im});
      checkOutput("vec_lat2", portOut(1'b1, vecs[i].port), {vecs[i].exp_re, vecs[i].exp_im});
    end
    idleInputs();
    addr_top = 8'h00;
    cycle();
    checkOutput("vec_isolate", {d0_top_re, d0_top_im}, {32'h7fffffff, 32'h80000000});

    // Scenario 1: io load into the shadow bank, swap, read back with both latencies
    applyStimulus(2'd2, 8'd5, 32'hfffffff9, 32'h3, 1'b1); cycle();
    applyStimulus(2'd2, 8'd6, 32'h1, 32'h2, 1'b1); cycle();
    idleInputs();
    swap_req = 1; cycle();
    swap_req = 0; cycle();
    checkOutput("s1_ack", {62'd0, d0_ack, d0_bank}, 64'd3);
    cycle();
    checkOutput("s1_ack_clear", {62'd0, d0_ack, d0_bank}, 64'd1);
    addr_top = 8'd5; cycle();
    checkOutput("s1_top_lat1", {d0_top_re, d0_top_im}, {32'hfffffff9, 32'h3});
    addr_top = 8'd6; cycle();
    checkOutput("s1_top_lat2", {d1_top_re, d1_top_im}, {32'hfffffff9, 32'h3});
    checkOutput("s1_top6_lat1", {d0_top_re, d0_top_im}, {32'h1, 32'h2});
    cycle();
    checkOutput("s1_top6_lat2", {d1_top_re, d1_top_im}, {32'h1, 32'h2});

    // Scenario 2: io writes never reach the active bank
    idleInputs();
    doSwap();
    checkOutput("s2_bank0", {63'd0, d0_bank}, 64'd0);
    applyStimulus(2'd0, 8'd9, 32'haaaa, 32'h5555, 1'b1); cycle();
    idleInputs();
    applyStimulus(2'd2, 8'd9, 32'h1234, 32'h1234, 1'b1); cycle();
    idleInputs();
    addr_top = 8'd9; io_addr = 8'd9; cycle();
    checkOutput("s2_prior", {d0_top_re, d0_top_im}, {32'haaaa, 32'h5555});
    doSwap();
    checkOutput("s2_after_swap", {d0_top_re, d0_top_im}, {32'h1234, 32'h1234});
    checkOutput("s2_io_other", {d0_io_re, d0_io_im}, {32'haaaa, 32'h5555});

    // Scenario 3: collision, clear, and clear losing to a new collision
    idleInputs();
    applyStimulus(2'd0, 8'h80, 32'd11, 32'd0, 1'b1);
    applyStimulus(2'd1, 8'h80, 32'd22, 32'd0, 1'b1);
    cycle();
    checkOutput("s3_coll_set", {63'd0, d0_coll}, 64'd1);
    idleInputs();
    addr_top = 8'h80; addr_bot = 8'h80; cycle();
    checkOutput("s3_top_wins", {d0_top_re, d0_top_im}, {32'd11, 32'd0});
    checkOutput("s3_bot_sees", {d0_bot_re, d0_bot_im}, {32'd11, 32'd0});
    clr_coll = 1; cycle(); clr_coll = 0;
    checkOutput("s3_coll_clr", {63'd0, d0_coll}, 64'd0);
    applyStimulus(2'd0, 8'h80, 32'd11, 32'd0, 1'b1);
    applyStimulus(2'd1, 8'h80, 32'd22, 32'd0, 1'b1);
    clr_coll = 1; cycle();
    checkOutput("s3_coll_wins", {63'd0, d0_coll}, 64'd1);
    idleInputs();
    clr_coll = 1; cycle(); clr_coll = 0;

    // Scenario 4: cross-port read-first
    applyStimulus(2'd0, 8'd3, 32'd100, 32'd0, 1'b1); cycle();
    applyStimulus(2'd0, 8'd3, 32'd200, 32'd0, 1'b1);
    addr_bot = 8'd3; cycle();
    checkOutput("s4_bot_old", {d0_bot_re, d0_bot_im}, {32'd100, 32'd0});
    checkOutput("s4_top_new", {d0_top_re, d0_top_im}, {32'd200, 32'd0});
    WE_top = 0; cycle();
    checkOutput("s4_bot_next", {d0_bot_re, d0_bot_im}, {32'd200, 32'd0});

    // Scenario 5: held request swaps once; drop and reassert swaps again (bank_sel starts at 1)
    idleInputs();
    acks = 0; toggles = 0; prev_bank = 1'b1;
    swap_req = 1;
    for (int c = 0; c < 10; c++) begin
      cycle();
      if (d0_ack) acks++;
      if (d0_bank != prev_bank) toggles++;
      prev_bank = d0_bank;
    end
    checkOutput("s5_held", {acks[31:0], toggles[31:0]}, {32'd1, 32'd1});
    checkOutput("s5_held_bank", {63'd0, d0_bank}, 64'd0);
    swap_req = 0; cycle();
    swap_req = 1;
    for (int c = 0; c < 5; c++) begin
      cycle();
      if (d0_ack) acks++;
      if (d0_bank != prev_bank) toggles++;
      prev_bank = d0_bank;
    end
    checkOutput("s5_reassert", {acks[31:0], toggles[31:0]}, {32'd2, 32'd2});
    checkOutput("s5_reassert_bank", {63'd0, d0_bank}, 64'd1);
    swap_req = 0; cycle(); cycle();
    swap_req = 1; cycle();
    #2 Reset_n = 0;
    #1;
    checkOutput("s5_async_rst0", {62'd0, d0_bank, d0_ack}, 64'd0);
    checkOutput("s5_async_rst1", {62'd0, d1_bank, d1_ack}, 64'd0);
    checkOutput("s5_async_dout", {d1_top_re, d1_top_im}, 64'd0);
    swap_req = 0;
    @(negedge Clk);
    Reset_n = 1;
    cycle(); cycle();
    checkOutput("s5_swap_lost", {61'd0, d0_bank, d0_ack, d0_coll}, 64'd0);

    // Initialise addresses 0..15 in both banks, then random traffic against the model
    for (int a = 0; a < 16; a++) begin
      idleInputs();
      applyStimulus(2'd0, a[7:0], $urandom, $urandom, 1'b1);
      applyStimulus(2'd2, a[7:0], $urandom, $urandom, 1'b1);
      addr_bot = a[7:0];
      cycle();
    end
    idleInputs();
    for (int c = 0; c < 10000; c++) begin
      WE_top = ($urandom_range(0, 3) == 0);
      WE_bot = ($urandom_range(0, 3) == 0);
      io_we  = ($urandom_range(0, 2) == 0);
      addr_top = 8'($urandom_range(0, 15));
      addr_bot = 8'($urandom_range(0, 15));
      io_addr  = 8'($urandom_range(0, 15));
      din_top_re = $urandom; din_top_im = $urandom;
      din_bot_re = $urandom; din_bot_im = $urandom;
      io_din_re  = $urandom; io_din_im  = $urandom;
      clr_coll = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 19) == 0) swap_req = ~swap_req;
      cycle();
      checkOutput("rnd_top0", {d0_top_re, d0_top_im}, m1_top);
      checkOutput("rnd_bot0", {d0_bot_re, d0_bot_im}, m1_bot);
      checkOutput("rnd_io0", {d0_io_re, d0_io_im}, m1_io);
      checkOutput("rnd_top1", {d1_top_re, d1_top_im}, m2_top);
      checkOutput("rnd_bot1", {d1_bot_re, d1_bot_im}, m2_bot);
      checkOutput("rnd_io1", {d1_io_re, d1_io_im}, m2_io);
      checkOutput("rnd_flags0", {61'd0, d0_bank, d0_ack, d0_coll}, {61'd0, m_bank, m_ack, m_coll});
      checkOutput("rnd_flags1", {61'd0, d1_bank, d1_ack, d1_coll}, {61'd0, m_bank, m_ack, m_coll});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
